fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the P5 pipelined MIPS core. Holds the PC, issues fetch requests to instruction memory over a req/ack handshake, buffers one instruction when decode is stalled, and presents `instr_D` to the decode-stage control decoder. Supports one architectural delay slot: a taken branch or jump reported from decode redirects the fetch after the delay slot, never the delay slot itself.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded at reset.

- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; low forces every register to its reset value immediately.
- `imem_req`  out  1  fetch request; address valid while high.
- `imem_addr`  out  32  fetch address (= PC); stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  single-cycle pulse, only while `imem_req`=1; `imem_rdata` valid that cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `stall`  in  1  from hazard unit: IF/ID register must hold.
- `redirect`  in  1  branch/jump in D is taken; ignored while `stall`=1.
- `redirect_pc`  in  32  target of the taken branch/jump.
- `instr_D`  out  32  IF/ID instruction (to control decoder).
- `pc_D`  out  32  address of `instr_D`.
- `pc8_D`  out  32  `pc_D`+8, link value for jal.
- `valid_D`  out  1  `instr_D` is a real instruction (0 = bubble).

## Operation
- Registers: `pc`, state {FETCH, FULL}, skid buffer (instr + addr), `pend` flag + `pend_pc`, IF/ID register.
- `imem_req` = (state==FETCH) and reset high; `imem_addr` = `pc`.
- Accept into D ("advance") whenever `stall`=0. Source priority: skid (FULL), else `imem_rdata` if `imem_ack`, else bubble (`instr_D`=0, `valid_D`=0; `pc_D` holds previous value).
- `stall`=1: IF/ID holds all fields.
- Next PC after an ack: `pend` ? `pend_pc` : `pc`+4 (32-bit wrap, no overflow detection); `pend` clears on use.
- FETCH, ack, advance: load D from rdata, update `pc`, stay FETCH.
- FETCH, ack, stall: load skid, update `pc`, go FULL.
- FETCH, no ack: hold `pc`, stay FETCH.
- FULL, advance: D loads skid, go FETCH. FULL, stall: hold.
- Redirect (qualified `redirect` & ~`stall`):
  - FETCH, no ack: in-flight fetch is the delay slot; set `pend`, `pend_pc`=`redirect_pc`.
  - FETCH, ack same cycle: rdata is the delay slot; `pc`<=`redirect_pc` directly, `pend` not set.
  - FULL: skid is the delay slot and enters D; `pc`<=`redirect_pc`, go FETCH.
- A second redirect while `pend`=1 cannot occur (delay slot is not a branch); `pend_pc` is overwritten if it does.
- Address alignment not checked; `imem_addr[1:0]` passed through.

## Timing
- Reset values: `pc`=`RESET_PC`, state=FETCH, `pend`=0, skid=0, `instr_D`=0, `pc_D`=0, `pc8_D`=8, `valid_D`=0, `imem_req`=0 while reset low, 1 in the first cycle after release.
- Ack in cycle t with `stall`=0 → `instr_D` valid after edge t (one-cycle latency ack→D).
- `imem_ack` tied high → one instruction per cycle, `pc` advances 4/cycle.
- Memory with N wait cycles → N bubbles per instruction.
- Skid depth exactly one; no fetch issued while FULL.
- `stall` and `redirect` sampled at the same edge; stall wins (redirect dropped, hazard unit re-asserts it).
- Reset mid-request: request dropped, ack in the reset cycle ignored, fetch restarts at `RESET_PC`.

## Test plan
- Reset release, ack tied high → `imem_addr` 0x3000, 0x3004, 0x3008 on consecutive cycles; `valid_D`=0 then 1 with `pc_D`=0x3000, `pc8_D`=0x3008.
- Ack tied high, `stall`=1 for 3 cycles at `pc_D`=0x3004 → `instr_D` holds, one word skidded (0x3008), `imem_req`=0 two cycles, release delivers 0x3008 then 0x300C.
- Branch at 0x3010 in D, `redirect`=1 to 0x3100, ack tied high → D sequence 0x3010, 0x3014, 0x3100.
- Same with 2-wait-cycle memory, redirect while 0x3014 outstanding → `imem_addr` stays 0x3014 until ack, then 0x3100; bubbles inserted.
- Redirect with `stall`=1 → ignored; `pc` sequence unchanged.
- Reset pulled low while `imem_req`=1 awaiting ack → all outputs at reset values immediately; after release fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: P5 MIPS instruction fetch, one-entry skid buffer and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        valid_D
);
  typedef enum logic {FETCH, FULL} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, pend_pc, pend_pc_nx, skid_instr, skid_pc;
  logic [31:0] d_instr_nx, d_pc_nx;
  logic pend, pend_nx, ack, redir, load_skid, d_valid_nx;
  assign imem_req  = (state == FETCH) && reset;
  assign imem_addr = pc;
  assign pc8_D     = pc_D + 32'd8;
  assign ack       = (state == FETCH) && imem_ack;
  assign redir     = redirect && !stall;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  // Whatever is handed to D when a redirect lands is the delay slot, so only
  // the fetch after it is steered: directly if pc already moved past it, via pend otherwise.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    pend_nx    = pend;
    pend_pc_nx = pend_pc;
    load_skid  = 1'b0;
    d_instr_nx = 32'd0;
    d_pc_nx    = pc_D;
    d_valid_nx = 1'b0;
    if (state == FULL) begin
      d_instr_nx = skid_instr;
      d_pc_nx    = skid_pc;
      d_valid_nx = 1'b1;
      state_nx   = stall ? FULL : FETCH;
      pc_nx      = redir ? redirect_pc : pc;
    end else if (ack) begin
      d_instr_nx = imem_rdata;
      d_pc_nx    = pc;
      d_valid_nx = 1'b1;
      pc_nx      = redir ? redirect_pc : pend ? pend_pc : pc + 32'd4;
      pend_nx    = 1'b0;
      load_skid  = stall;
      state_nx   = stall ? FULL : FETCH;
    end else if (redir) begin
      pend_nx    = 1'b1;
      pend_pc_nx = redirect_pc;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc         <= RESET_PC;
      pend       <= 1'b0;
      pend_pc    <= 32'd0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      instr_D    <= 32'd0;
      pc_D       <= 32'd0;
      valid_D    <= 1'b0;
    end else begin
      pc      <= pc_nx;
      pend    <= pend_nx;
      pend_pc <= pend_pc_nx;
      if (load_skid) begin
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
      end
      if (!stall) begin
        instr_D <= d_instr_nx;
        pc_D    <= d_pc_nx;
        valid_D <= d_valid_nx;
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized scoreboard bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  logic clk = 1'b0, reset = 1'b0, imem_ack = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] imem_rdata = 32'd0, redirect_pc = 32'd0;
  logic imem_req, valid_D;
  logic [31:0] imem_addr, instr_D, pc_D, pc8_D;
  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_D(instr_D), .pc_D(pc_D), .pc8_D(pc8_D), .valid_D(valid_D)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, n_pop = 0;
  int minw = 0, maxw = 0, wcnt = 0;
  bit mon_en = 1'b0, mon_took;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e, br_target = 32'd0;
  bit br_armed = 1'b0, in_ds = 1'b0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  // Instruction memory: ack after a random wait in [minw, maxw] cycles.
  always @(negedge clk) begin
    imem_ack = 1'b0;
    if (!reset) wcnt = 0;
    else if (imem_req) begin
      if (wcnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        wcnt       = $urandom_range(maxw, minw);
      end else wcnt--;
    end
  end
  // Architectural model: stream is sequential, except the entry after a
  // branch's delay slot is the branch target.
  always @(posedge clk) begin
    mon_took = reset && !stall;
    #1;
    if (mon_en && mon_took && reset) begin
      if (valid_D) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard: got pc_D %h, expected nothing", pc_D);
        end else begin
          mon_e = exp_q.pop_front();
          n_pop++;
          check("pc_D", pc_D, mon_e);
          check("instr_D", instr_D, word(mon_e));
          check("pc8_D", pc8_D, mon_e + 32'd8);
          exp_q.push_back(br_armed ? br_target : mon_e + 32'd4);
          in_ds    = br_armed;
          br_armed = 1'b0;
        end
      end else check("bubble instr_D", instr_D, 32'd0);
    end
  end
  task automatic model_flush();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    br_armed = 1'b0;
    in_ds    = 1'b0;
  endtask
  task automatic take_branch(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    br_armed    = 1'b1;
    br_target   = t;
  endtask
  initial begin
    logic [31:0] p;
    int held;
    bit found;
    repeat (3) @(negedge clk);
    check("rst instr_D", instr_D, 32'd0);
    check("rst pc_D", pc_D, 32'd0);
    check("rst pc8_D", pc8_D, 32'd8);
    check("rst valid_D", {31'd0, valid_D}, 32'd0);
    check("rst imem_req", {31'd0, imem_req}, 32'd0);
    model_flush();
    mon_en = 1'b1;
    @(posedge clk); #2 reset = 1'b1;
    #1 check("req after release", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    check("addr0", imem_addr, 32'h3000);
    check("valid0", {31'd0, valid_D}, 32'd0);
    @(negedge clk);
    check("addr1", imem_addr, 32'h3004);
    check("valid1", {31'd0, valid_D}, 32'd1);
    check("pc_D1", pc_D, 32'h3000);
    check("pc8_D1", pc8_D, 32'h3008);
    @(negedge clk);
    check("addr2", imem_addr, 32'h3008);
    check("pc_D2", pc_D, 32'h3004);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall req", {31'd0, imem_req}, 32'd0);
      check("stall pc_D", pc_D, 32'h3004);
      check("stall instr_D", instr_D, word(32'h3004));
    end
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    check("skid out pc_D", pc_D, 32'h3008);
    check("skid out addr", imem_addr, 32'h300C);
    @(negedge clk);
    check("after skid pc_D", pc_D, 32'h300C);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      found = (pc_D == 32'h3010);
    end
    check("reach 0x3010", {31'd0, found}, 32'd1);
    take_branch(32'h3100);
    @(negedge clk);
    redirect = 1'b0;
    check("delay slot pc_D", pc_D, 32'h3014);
    check("redirect addr", imem_addr, 32'h3100);
    @(negedge clk);
    check("target pc_D", pc_D, 32'h3100);
    p = pc_D;
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h3200;
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    check("stalled redirect hold", pc_D, p);
    @(negedge clk);
    check("stalled redirect seq1", pc_D, p + 32'd4);
    @(negedge clk);
    check("stalled redirect seq2", pc_D, p + 32'd8);
    minw = 2; maxw = 2;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      found = valid_D && !br_armed && !in_ds;
    end
    check("wait-mode instr", {31'd0, found}, 32'd1);
    p = pc_D;
    check("outstanding addr", imem_addr, p + 32'd4);
    take_branch(32'h3400);
    @(negedge clk);
    redirect = 1'b0;
    held = 0;
    while (imem_addr == p + 32'd4 && held < 10) begin
      held++;
      @(negedge clk);
    end
    check("addr held till ack", {31'd0, held > 0}, 32'd1);
    check("addr after pend", imem_addr, 32'h3400);
    minw = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 500 == 0) maxw = $urandom_range(2, 0);
      stall = 1'b0;
      redirect = 1'b0;
      if (i == 1500) begin
        minw = 1; maxw = 2;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
          @(negedge clk);
          #1 found = imem_req && !imem_ack;
        end
        check("request pending", {31'd0, found}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst req", {31'd0, imem_req}, 32'd0);
        check("midrst valid_D", {31'd0, valid_D}, 32'd0);
        check("midrst instr_D", instr_D, 32'd0);
        check("midrst pc_D", pc_D, 32'd0);
        check("midrst pc8_D", pc8_D, 32'd8);
        model_flush();
        minw = 0;
        @(posedge clk); #2 reset = 1'b1;
        #1 check("restart addr", imem_addr, RESET_PC);
      end else begin
        stall = ($urandom_range(3, 0) == 0);
        if (!stall && valid_D && !br_armed && !in_ds && $urandom_range(2, 0) == 0)
          take_branch($urandom & 32'h000F_FFFC);
        else if (stall && $urandom_range(1, 0) == 0) begin
          redirect = 1'b1;
          redirect_pc = $urandom;
        end
      end
    end
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    repeat (10) @(negedge clk);
    check("progress", {31'd0, n_pop >= 1000}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
